// File: rtl/page_walker.sv
// Three-level (Sv39-style) hardware page-table walker: turns a TLB miss into
// up to three PTE reads and returns one refill, flagging faults with a zero PA.
module page_walker #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [43:0] satp_ppn,
    input  logic        miss_valid,
    output logic        miss_ready,
    input  logic [63:0] miss_va,
    input  logic [11:0] miss_pcid,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,
    output logic        fill_valid,
    input  logic        fill_ready,
    output logic [63:0] fill_va,
    output logic [11:0] fill_pcid,
    output logic [63:0] fill_pa,
    output logic        fill_fault
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW:0] TIMEOUT_W = (CW + 1)'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

    state_t        state_reg, state_next;
    logic [1:0]    level_reg, level_next;
    logic [63:0]   va_reg, va_next;
    logic [11:0]   pcid_reg, pcid_next;
    logic [43:0]   ppn_reg, ppn_next;
    logic [63:0]   pa_reg, pa_next;
    logic          fault_reg, fault_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic          pte_v, pte_r, pte_w, pte_x;
    logic [43:0]   pte_ppn;
    logic          pte_invalid, pte_leaf, leaf_misaligned;
    logic [63:0]   leaf_pa;
    logic [8:0]    vpn [3];
    logic [8:0]    vpn_sel;
    logic          va_canonical;
    logic [CW:0]   cnt_plus;
    logic          timeout_hit;
    logic          unused_pte_bits;

    // Virtual page-number slices, one per translation level
    for (genvar gi = 0; gi < 3; gi++) begin : g_vpn
        assign vpn[gi] = va_reg[12 + 9*gi +: 9];
    end

    assign vpn_sel = (level_reg == 2'd2) ? vpn[2] :
                     (level_reg == 2'd1) ? vpn[1] : vpn[0];

    assign mem_req_addr = {8'b0, ppn_reg, 12'b0} + {52'b0, vpn_sel, 3'b000};

    assign pte_v   = mem_resp_data[0];
    assign pte_r   = mem_resp_data[1];
    assign pte_w   = mem_resp_data[2];
    assign pte_x   = mem_resp_data[3];
    assign pte_ppn = mem_resp_data[53:10];
    assign unused_pte_bits = ^{mem_resp_data[63:54], mem_resp_data[9:4]};

    assign pte_invalid = !pte_v || (pte_w && !pte_r);
    assign pte_leaf    = pte_r || pte_x;

    // Superpages must be naturally aligned; the low PPN bits are replaced by VA bits
    assign leaf_misaligned = ((level_reg == 2'd2) && (|pte_ppn[17:0])) ||
                             ((level_reg == 2'd1) && (|pte_ppn[8:0]));

    always_comb begin
        case (level_reg)
            2'd2:    leaf_pa = {8'b0, pte_ppn[43:18], va_reg[29:0]};
            2'd1:    leaf_pa = {8'b0, pte_ppn[43:9], va_reg[20:0]};
            default: leaf_pa = {8'b0, pte_ppn, va_reg[11:0]};
        endcase
    end

    assign va_canonical = (&miss_va[63:38]) || !(|miss_va[63:38]);

    // A response in the same cycle wins over the timeout (checked first below)
    assign cnt_plus    = {1'b0, cnt_reg} + (CW + 1)'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_plus == TIMEOUT_W);

    always_comb begin
        state_next    = state_reg;
        level_next    = level_reg;
        va_next       = va_reg;
        pcid_next     = pcid_reg;
        ppn_next      = ppn_reg;
        pa_next       = pa_reg;
        fault_next    = fault_reg;
        cnt_next      = cnt_reg;
        miss_ready    = (state_reg == IDLE);
        mem_req_valid = (state_reg == REQ);
        fill_valid    = (state_reg == FILL);

        case (state_reg)
            IDLE: begin
                if (miss_valid) begin
                    va_next    = miss_va;
                    pcid_next  = miss_pcid;
                    ppn_next   = satp_ppn;
                    level_next = 2'd2;
                    cnt_next   = '0;
                    pa_next    = '0;
                    fault_next = !va_canonical;
                    state_next = va_canonical ? REQ : FILL;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    cnt_next   = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    if (pte_invalid || (pte_leaf && leaf_misaligned) ||
                        (!pte_leaf && level_reg == 2'd0)) begin
                        fault_next = 1'b1;
                        pa_next    = '0;
                        state_next = FILL;
                    end else if (pte_leaf) begin
                        fault_next = 1'b0;
                        pa_next    = leaf_pa;
                        state_next = FILL;
                    end else begin
                        ppn_next   = pte_ppn;
                        level_next = level_reg - 2'd1;
                        state_next = REQ;
                    end
                end else if (timeout_hit) begin
                    fault_next = 1'b1;
                    pa_next    = '0;
                    state_next = FILL;
                end else if (TIMEOUT != 0) begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            FILL: begin
                if (fill_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            level_reg <= 2'd2;
            va_reg    <= '0;
            pcid_reg  <= '0;
            ppn_reg   <= '0;
            pa_reg    <= '0;
            fault_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
            va_reg    <= va_next;
            pcid_reg  <= pcid_next;
            ppn_reg   <= ppn_next;
            pa_reg    <= pa_next;
            fault_reg <= fault_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign fill_va    = va_reg;
    assign fill_pcid  = pcid_reg;
    assign fill_pa    = pa_reg;
    assign fill_fault = fault_reg;

endmodule

// File: doc/page_walker.md
PAGE_WALKER -- requirements
Module: page_walker

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles spent in WAIT per memory access; 0 disables the timeout.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port satp_ppn  input  44  root page-table PPN, sampled on miss accept.
REQ-005 SHALL have ports miss_valid (input, 1), miss_ready (output, 1), miss_va (input, 64) and miss_pcid (input, 12): the TLB miss request.
REQ-006 SHALL have ports mem_req_valid (output, 1), mem_req_ready (input, 1) and mem_req_addr (output, 64): the PTE read request.
REQ-007 SHALL have ports mem_resp_valid (input, 1) and mem_resp_data (input, 64): the PTE read response, with no back-pressure.
REQ-008 SHALL have ports fill_valid (output, 1), fill_ready (input, 1), fill_va (output, 64), fill_pcid (output, 12), fill_pa (output, 64) and fill_fault (output, 1): the refill toward the TLB cache.

Function
REQ-009 SHALL implement states IDLE, REQ, WAIT and FILL, plus a 2-bit level register (2, 1, 0).
REQ-010 SHALL assert miss_ready only in IDLE, and accept a miss on miss_valid&miss_ready.
REQ-011 On accept, SHALL latch va, pcid and satp_ppn, and set level=2.
REQ-012 On accept of a non-canonical va (va[63:39] not all equal to va[38]), SHALL go directly to FILL with fault=1 and issue no memory request.
REQ-013 On accept of a canonical va, SHALL go to REQ.
REQ-014 In REQ, SHALL assert mem_req_valid with mem_req_addr = {8'b0, ppn, 12'b0} + VPN[level]*8, where VPN2=va[38:30], VPN1=va[29:21] and VPN0=va[20:12].
REQ-015 SHALL hold mem_req_addr stable until the request handshake, then go to WAIT.
REQ-016 SHALL accept mem_resp_valid only in WAIT, earliest the cycle after the request handshake; responses in other states SHALL be ignored.
REQ-017 SHALL decode each PTE as V=bit0, R=bit1, W=bit2, X=bit3 and PPN=bits[53:10].
REQ-018 An invalid PTE (V=0, or W=1 with R=0) SHALL produce FILL with fault=1.
REQ-019 A pointer PTE (V=1, R=0, X=0) at level>0 SHALL set ppn=PTE.PPN, decrement level and return to REQ.
REQ-020 A pointer PTE at level 0 SHALL produce FILL with fault=1.
REQ-021 A leaf PTE (R|X) SHALL produce FILL with fault=0 and fill_pa = {8'b0, PPN[43:18], va[29:0]} at level 2, {8'b0, PPN[43:9], va[20:0]} at level 1, and {8'b0, PPN, va[11:0]} at level 0.
REQ-022 A leaf PTE with a misaligned superpage (level 2 with PPN[17:0]≠0, or level 1 with PPN[8:0]≠0) SHALL produce FILL with fault=1.
REQ-023 SHALL count cycles in WAIT per memory access; when the count reaches TIMEOUT (TIMEOUT≠0), SHALL go to FILL with fault=1.
REQ-024 A response arriving in the same cycle the count reaches TIMEOUT SHALL take priority over the timeout.
REQ-025 In FILL, SHALL assert fill_valid and hold fill_va, fill_pcid, fill_pa and fill_fault stable until fill_ready, then return to IDLE.
REQ-026 SHALL drive fill_pa=0 whenever fill_fault=1.
REQ-027 SHALL handle exactly one walk at a time; miss_ready SHALL stay 0 from accept until the cycle after the fill handshake.

Reset
REQ-028 While rst=1 at a clock edge, SHALL enter IDLE with level=2, timeout count=0, miss_ready=1 and mem_req_valid=0.
REQ-029 While rst=1 at a clock edge, SHALL drive fill_valid=0, fill_fault=0, fill_pa=0, fill_va=0 and fill_pcid=0.
REQ-030 Reset mid-walk SHALL abandon the walk with no fill, and a late memory response after reset SHALL be ignored.

Verification
REQ-031 3-level walk: satp_ppn=0x80000, va=0x40203000, pcid=0x5 -> requests 0x80000008, 0x80001008 and 0x80002018, answered with responses 0x20000401, 0x20000801 and 0x2400000F -> fill_pa=0x90000000, fault=0, pcid=0x5.
REQ-032 Gigapage: same va, first response 0x1000000F -> one request only, fill_pa=0x40203000, fault=0; with first response 0x2400000F instead -> fault=1, fill_pa=0.
REQ-033 Faults: va=0x0000_8000_0000_0000 -> zero memory requests, fault=1; first response 0x0 (V=0) -> fault=1 after one request.
REQ-034 Back-pressure: mem_req_ready low 5 cycles then high, and fill_ready low 3 cycles -> request address and fill outputs held stable throughout, miss_ready=0 throughout.
REQ-035 Timeout: TIMEOUT=4, no response -> fill with fault=1 exactly 4 cycles after the request handshake; a response sent afterwards is ignored.
REQ-036 Reset mid-WAIT, then a response pulse -> no fill_valid, miss_ready=1 the cycle after reset deasserts.
